// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard unit <-> pipeline control bundle.
// Ports: stall/hazard inputs, stage enables, flushes, watchdog, perf counters.
// master = pipeline side, slave = hazard_ctrl side.
interface hazard_ctrl_if #(
    parameter int RA_W = 5
);
    logic            icache_stall;
    logic            dcache_stall;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic            id_jump;
    logic            ex_memread;
    logic [RA_W-1:0] ex_rd;
    logic            ex_br_taken;

    logic            pc_write;
    logic            ifid_write;
    logic            ifid_flush;
    logic            hazard_flush;
    logic            idex_write;
    logic            exmem_write;
    logic            memwb_write;
    logic            stall_timeout;
    logic [31:0]     perf_stall;
    logic [31:0]     perf_bubble;
    logic [31:0]     perf_flush;

    modport master (
        output icache_stall, dcache_stall,
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output id_jump, ex_memread, ex_rd, ex_br_taken,
        input  pc_write, ifid_write, ifid_flush,
        input  hazard_flush, idex_write,
        input  exmem_write, memwb_write, stall_timeout,
        input  perf_stall, perf_bubble, perf_flush
    );

    modport slave (
        input  icache_stall, dcache_stall,
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  id_jump, ex_memread, ex_rd, ex_br_taken,
        output pc_write, ifid_write, ifid_flush,
        output hazard_flush, idex_write,
        output exmem_write, memwb_write, stall_timeout,
        output perf_stall, perf_bubble, perf_flush
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline sequencing (freeze, load-use, redirect, jump).
// Ports: clk, rst_n (sync, active low), hz (hazard_ctrl_if.slave bundle).
// HAZARD_CTRL_PERF_EN builds the perf counters; otherwise perf_* read 0.
module hazard_ctrl #(
    parameter int RA_W    = 5,
    parameter int TIMEOUT = 1023,
    parameter int TMO_W   = 10
) (
    input logic         clk,
    input logic         rst_n,
    hazard_ctrl_if.slave hz
);
    typedef enum logic {RUN, FRZ} state_t;

    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

    state_t           state;
    state_t           state_nxt;
    logic             redir_pend;
    logic [TMO_W-1:0] cnt;
    logic [TMO_W-1:0] cnt_nxt;
    logic [TMO_W-1:0] cnt_base;
    logic             tmo;
    logic             tmo_hit;

    logic             freeze;
    logic             load_use;
    logic [RA_W-1:0]  rd;
    logic             set_pend;
    logic             clr_pend;
    logic             ev_bubble;
    logic             ev_flush;

    assign freeze = hz.icache_stall | hz.dcache_stall;
    assign rd     = hz.ex_rd;

    assign load_use = hz.ex_memread && (rd != '0) &&
                      ((hz.id_use_rs1 && hz.id_rs1 == rd) ||
                       (hz.id_use_rs2 && hz.id_rs2 == rd));

    always_comb begin
        state_nxt       = freeze ? FRZ : RUN;
        hz.pc_write     = 1'b1;
        hz.ifid_write   = 1'b1;
        hz.ifid_flush   = 1'b0;
        hz.hazard_flush = 1'b0;
        hz.idex_write   = 1'b1;
        hz.exmem_write  = 1'b1;
        hz.memwb_write  = 1'b1;
        set_pend        = 1'b0;
        clr_pend        = 1'b0;
        ev_bubble       = 1'b0;
        ev_flush        = 1'b0;
        if (!rst_n) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_write  = 1'b0;
            hz.exmem_write = 1'b0;
            hz.memwb_write = 1'b0;
        end else if (freeze) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_write  = 1'b0;
            hz.exmem_write = 1'b0;
            hz.memwb_write = 1'b0;
            // The branch stays held in EX; replay its redirect later.
            set_pend       = hz.ex_br_taken;
        end else if (hz.ex_br_taken || redir_pend) begin
            hz.ifid_flush   = 1'b1;
            hz.hazard_flush = 1'b1;
            clr_pend        = 1'b1;
            ev_flush        = 1'b1;
        end else if (load_use) begin
            hz.pc_write     = 1'b0;
            hz.ifid_write   = 1'b0;
            hz.hazard_flush = 1'b1;
            ev_bubble       = 1'b1;
        end else if (hz.id_jump) begin
            hz.ifid_flush = 1'b1;
            ev_flush      = 1'b1;
        end
    end

    // First freeze cycle (still in RUN) restarts the count at 1.
    always_comb begin
        cnt_base = (state == FRZ) ? cnt : '0;
        cnt_nxt  = '0;
        if (freeze) begin
            cnt_nxt = (cnt_base == TMO_MAX) ? cnt_base
                                            : cnt_base + 1'b1;
        end
        tmo_hit = freeze && (cnt_nxt == TMO_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            redir_pend <= 1'b0;
            cnt        <= '0;
            tmo        <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (set_pend) begin
                redir_pend <= 1'b1;
            end else if (clr_pend) begin
                redir_pend <= 1'b0;
            end
            if (tmo_hit) begin
                tmo <= 1'b1;
            end
        end
    end

    assign hz.stall_timeout = tmo & rst_n;

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] p_stall;
    logic [31:0] p_bubble;
    logic [31:0] p_flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_stall  <= '0;
            p_bubble <= '0;
            p_flush  <= '0;
        end else begin
            if (freeze) begin
                p_stall <= p_stall + 32'd1;
            end
            if (ev_bubble) begin
                p_bubble <= p_bubble + 32'd1;
            end
            if (ev_flush) begin
                p_flush <= p_flush + 32'd1;
            end
        end
    end

    assign hz.perf_stall  = p_stall;
    assign hz.perf_bubble = p_bubble;
    assign hz.perf_flush  = p_flush;
`else
    logic unused_ev;
    assign unused_ev      = ev_bubble ^ ev_flush;
    assign hz.perf_stall  = 32'd0;
    assign hz.perf_bubble = 32'd0;
    assign hz.perf_flush  = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors plus a per-cycle reference model.
// Ports: none (top-level bench).
module tb_hazard_ctrl;
    localparam int TIMEOUT = 8;

`ifdef HAZARD_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    hazard_ctrl_if #(.RA_W(5)) bus ();

    hazard_ctrl #(
        .RA_W   (5),
        .TIMEOUT(TIMEOUT),
        .TMO_W  (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: event-level bookkeeping.
    bit          m_ok   = 1'b0;
    bit          m_pend = 1'b0;
    int          m_run  = 0;
    bit          m_tmo  = 1'b0;
    int unsigned m_ps   = 0;
    int unsigned m_pb   = 0;
    int unsigned m_pf   = 0;

    function automatic bit lu_now();
        return bus.ex_memread && bus.ex_rd != 5'd0 &&
               ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
                (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
    endfunction

    function automatic bit frz_now();
        return bus.icache_stall || bus.dcache_stall;
    endfunction

    // {pc, ifid_w, ifid_f, haz_f, idex, exmem, memwb}
    function automatic logic [6:0] exp_en();
        if (!rst_n)                       return 7'b0000000;
        if (frz_now())                    return 7'b0000000;
        if (bus.ex_br_taken || m_pend)    return 7'b1111111;
        if (lu_now())                     return 7'b0001111;
        if (bus.id_jump)                  return 7'b1110111;
        return 7'b1100111;
    endfunction

    function automatic logic [6:0] dut_en();
        return {bus.pc_write, bus.ifid_write, bus.ifid_flush,
                bus.hazard_flush, bus.idex_write,
                bus.exmem_write, bus.memwb_write};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ok   <= 1'b1;
            m_pend <= 1'b0;
            m_run  <= 0;
            m_tmo  <= 1'b0;
            m_ps   <= 0;
            m_pb   <= 0;
            m_pf   <= 0;
        end else if (frz_now()) begin
            m_run <= m_run + 1;
            m_ps  <= m_ps + 1;
            if (m_run + 1 >= TIMEOUT) m_tmo <= 1'b1;
            if (bus.ex_br_taken) m_pend <= 1'b1;
        end else begin
            m_run <= 0;
            if (bus.ex_br_taken || m_pend) begin
                m_pend <= 1'b0;
                m_pf   <= m_pf + 1;
            end else if (lu_now()) begin
                m_pb <= m_pb + 1;
            end else if (bus.id_jump) begin
                m_pf <= m_pf + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [6:0]  ee;
        logic        et;
        logic [31:0] es, eb, ef;
        if (m_ok) begin
            ee = exp_en();
            et = m_tmo && rst_n;
            es = PERF ? m_ps : 32'd0;
            eb = PERF ? m_pb : 32'd0;
            ef = PERF ? m_pf : 32'd0;
            total++;
            if (dut_en() == ee && bus.stall_timeout == et &&
                bus.perf_stall == es && bus.perf_bubble == eb &&
                bus.perf_flush == ef) begin
                passed++;
            end else begin
                $display("FAIL model t=%0t en=%b/%b tmo=%b/%b perf=%0d,%0d,%0d/%0d,%0d,%0d",
                         $time, dut_en(), ee, bus.stall_timeout, et,
                         bus.perf_stall, bus.perf_bubble, bus.perf_flush,
                         es, eb, ef);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.icache_stall = 1'b0;
        bus.dcache_stall = 1'b0;
        bus.id_rs1       = 5'd0;
        bus.id_rs2       = 5'd0;
        bus.id_use_rs1   = 1'b0;
        bus.id_use_rs2   = 1'b0;
        bus.id_jump      = 1'b0;
        bus.ex_memread   = 1'b0;
        bus.ex_rd        = 5'd0;
        bus.ex_br_taken  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        lit("rst_en", 32'(dut_en()), 32'h0);
        lit("rst_tmo", 32'(bus.stall_timeout), 32'h0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        // T1
        tick();
        do_reset();
        @(negedge clk);
        lit("t1_run", 32'(dut_en()), 32'h67);
        lit("t1_perf", bus.perf_stall | bus.perf_bubble, 32'h0);

        // T2 load-use on rs2, then ex_rd=0, then rs1
        tick();
        bus.ex_memread = 1'b1;
        bus.ex_rd      = 5'd5;
        bus.id_rs2     = 5'd5;
        bus.id_use_rs2 = 1'b1;
        @(negedge clk);
        lit("t2_bubble", 32'(dut_en()), 32'h0F);
        tick();
        bus.ex_memread = 1'b0;
        @(negedge clk);
        lit("t2_after", 32'(dut_en()), 32'h67);
        tick();
        bus.ex_memread = 1'b1;
        bus.ex_rd      = 5'd0;
        bus.id_rs2     = 5'd0;
        @(negedge clk);
        lit("t2_x0", 32'(dut_en()), 32'h67);
        tick();
        bus.ex_rd      = 5'd7;
        bus.id_rs1     = 5'd7;
        bus.id_use_rs1 = 1'b1;
        bus.id_use_rs2 = 1'b0;
        @(negedge clk);
        lit("t2_rs1", 32'(dut_en()), 32'h0F);
        tick();
        idle();

        // T3 branch resolved inside a 4-cycle freeze
        bus.dcache_stall = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            bus.ex_br_taken = (c == 2);
            @(negedge clk);
            lit($sformatf("t3_frz%0d", c), 32'(dut_en()), 32'h0);
            tick();
        end
        idle();
        @(negedge clk);
        lit("t3_redir", 32'(dut_en()), 32'h7F);
        tick();
        @(negedge clk);
        lit("t3_norm", 32'(dut_en()), 32'h67);
        tick();

        // T4 branch + load-use + jump together
        bus.ex_br_taken = 1'b1;
        bus.ex_memread  = 1'b1;
        bus.ex_rd       = 5'd3;
        bus.id_rs1      = 5'd3;
        bus.id_use_rs1  = 1'b1;
        bus.id_jump     = 1'b1;
        @(negedge clk);
        lit("t4_en", 32'(dut_en()), 32'h7F);
        tick();
        idle();
        @(negedge clk);
        lit("t4_pflush", bus.perf_flush, PERF ? 32'd2 : 32'd0);
        lit("t4_pbub", bus.perf_bubble, PERF ? 32'd2 : 32'd0);
        lit("t4_pstall", bus.perf_stall, PERF ? 32'd4 : 32'd0);

        // T5 watchdog
        tick();
        bus.icache_stall = 1'b1;
        for (int c = 0; c < TIMEOUT; c++) begin
            @(negedge clk);
            if (c == TIMEOUT - 1)
                lit("t5_pre", 32'(bus.stall_timeout), 32'h0);
            tick();
        end
        bus.icache_stall = 1'b0;
        @(negedge clk);
        lit("t5_set", 32'(bus.stall_timeout), 32'h1);
        tick();
        tick();
        @(negedge clk);
        lit("t5_sticky", 32'(bus.stall_timeout), 32'h1);
        tick();
        do_reset();
        @(negedge clk);
        lit("t5_clr", 32'(bus.stall_timeout), 32'h0);
        tick();

        // T6 perf: 3 freeze, 2 bubbles, 1 jump
        bus.icache_stall = 1'b1;
        tick();
        tick();
        tick();
        idle();
        bus.ex_memread = 1'b1;
        bus.ex_rd      = 5'd9;
        bus.id_rs2     = 5'd9;
        bus.id_use_rs2 = 1'b1;
        tick();
        tick();
        idle();
        bus.id_jump = 1'b1;
        @(negedge clk);
        lit("t6_jump", 32'(dut_en()), 32'h77);
        tick();
        idle();
        @(negedge clk);
        lit("t6_stall", bus.perf_stall, PERF ? 32'd3 : 32'd0);
        lit("t6_bubble", bus.perf_bubble, PERF ? 32'd2 : 32'd0);
        lit("t6_flush", bus.perf_flush, PERF ? 32'd1 : 32'd0);

        // Reset in the middle of a freeze with a pending redirect
        tick();
        bus.dcache_stall = 1'b1;
        bus.ex_br_taken  = 1'b1;
        tick();
        bus.ex_br_taken  = 1'b0;
        do_reset();
        bus.dcache_stall = 1'b0;
        @(negedge clk);
        lit("rst_mid", 32'(dut_en()), 32'h67);
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
